// File: rtl/axis_bram_adapter_v1_0_rd_stream_if.sv
// AXI-Stream link carrying words out of the BRAM read stream engine.
interface axis_bram_adapter_v1_0_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_bram_adapter_v1_0_rd_stream.sv
// Reads an inclusive BRAM address range and streams it out over AXI-Stream,
// absorbing the BRAM read latency through a credit-managed output FIFO.
module axis_bram_adapter_v1_0_rd_stream #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned BRAM_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] index_cntl,
  input  logic [ADDR_WIDTH-1:0] size_cntl,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_index,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  axis_bram_adapter_v1_0_rd_stream_if.master m_axis
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // spare bit so fifo_count + inflight cannot wrap
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1) + 1;

  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH:0]     remaining;
  logic                    issue_last;
  logic [ADDR_WIDTH-1:0]   span;

  logic [BRAM_LATENCY-1:0] tag_vld;
  logic [BRAM_LATENCY-1:0] tag_last;

  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        inflight;

  logic                    issue;
  logic                    push;
  logic                    push_last;
  logic                    pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign span      = size_cntl - index_cntl;
  assign push      = tag_vld[BRAM_LATENCY-1];
  assign push_last = tag_last[BRAM_LATENCY-1];
  assign pop       = m_axis.tvalid & m_axis.tready;

  // Credit check uses the occupancy before this cycle's pop, so the FIFO can
  // never be full when an in-flight word lands.
  assign issue = (state == S_RUN) && (remaining != '0) &&
                 ((fifo_count + inflight) < DEPTH_C);

  assign m_axis.tvalid = (fifo_count != '0);
  assign m_axis.tdata  = m_axis.tvalid ? fifo_data[rd_ptr] : '0;
  assign m_axis.tlast  = m_axis.tvalid & fifo_last[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin : fsm
    if (!rstn) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bram_en    <= 1'b0;
      bram_index <= '0;
      addr       <= '0;
      remaining  <= '0;
      issue_last <= 1'b0;
    end else begin
      bram_en <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= index_cntl;
            remaining <= {1'b0, span} + REM_ONE;
            busy      <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            bram_en    <= 1'b1;
            bram_index <= addr;
            issue_last <= (remaining == REM_ONE);
            addr       <= addr + ADDR_ONE;
            remaining  <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && m_axis.tlast) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Tags trail bram_en by BRAM_LATENCY cycles, lining up with bram_dout.
  always_ff @(posedge clk or negedge rstn) begin : datapath
    if (!rstn) begin
      tag_vld    <= '0;
      tag_last   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      tag_vld  <= (tag_vld << 1) | BRAM_LATENCY'(bram_en);
      tag_last <= (tag_last << 1) | BRAM_LATENCY'(issue_last);

      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase

      case ({issue, push})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin : fifo_store
    if (push) begin
      fifo_data[wr_ptr] <= bram_dout;
      fifo_last[wr_ptr] <= push_last;
    end
  end

endmodule

// File: tb/tb_axis_bram_adapter_v1_0_rd_stream.sv
// Randomized self-checking bench for the BRAM read stream engine (latency 1 and 2 builds).
module tb_axis_bram_adapter_v1_0_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        start1, start2;
  logic [8:0]  idx1, sz1, idx2, sz2;
  logic        busy1, done1, en1, busy2, done2, en2;
  logic [8:0]  bidx1, bidx2;
  logic [31:0] dout1, dout2, ra2;

  axis_bram_adapter_v1_0_rd_stream_if #(.DATA_WIDTH(32)) ax1 ();
  axis_bram_adapter_v1_0_rd_stream_if #(.DATA_WIDTH(32)) ax2 ();

  axis_bram_adapter_v1_0_rd_stream #(
    .DATA_WIDTH(32), .ADDR_WIDTH(9), .BRAM_LATENCY(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start1), .index_cntl(idx1), .size_cntl(sz1),
    .busy(busy1), .done(done1), .bram_en(en1), .bram_index(bidx1),
    .bram_dout(dout1), .m_axis(ax1)
  );

  axis_bram_adapter_v1_0_rd_stream #(
    .DATA_WIDTH(32), .ADDR_WIDTH(9), .BRAM_LATENCY(2), .FIFO_DEPTH(5)
  ) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .index_cntl(idx2), .size_cntl(sz2),
    .busy(busy2), .done(done2), .bram_en(en2), .bram_index(bidx2),
    .bram_dout(dout2), .m_axis(ax2)
  );

  // BRAM models: one and two cycles of read latency
  logic [31:0] mem [512];
  always @(posedge clk) if (en1) dout1 <= mem[bidx1];
  always @(posedge clk) begin
    if (en2) ra2 <= mem[bidx2];
    dout2 <= ra2;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Observations gathered by run_xfer
  logic [31:0] got_data [$];
  bit          got_last [$];
  int          got_cyc  [$];
  int          got_idx  [$];
  int start_cyc, first_valid, done_cyc, busy_gap, hold_err, max_ahead;
  bit timed_out;

  function automatic int exp_n(input int idx, input int sz);
    return (((sz - idx) % 512) + 512) % 512 + 1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Starts a transfer and records every beat, issue and status until done.
  task automatic run_xfer(input int sel, input int idx, input int sz, input int mode,
                          input int restart_at, input int rs_idx, input int rs_sz);
    logic v, l, b, d, e, r, prev_stall, prev_l;
    logic [31:0] dat, prev_dat;
    logic [8:0] bi;
    int issues;
    got_data.delete(); got_last.delete(); got_cyc.delete(); got_idx.delete();
    first_valid = -1; done_cyc = -1; busy_gap = 0; hold_err = 0; max_ahead = 0;
    timed_out = 1'b1; issues = 0; prev_stall = 1'b0; prev_dat = '0; prev_l = 1'b0;
    if (sel == 0) begin start1 = 1'b1; idx1 = 9'(idx); sz1 = 9'(sz); end
    else          begin start2 = 1'b1; idx2 = 9'(idx); sz2 = 9'(sz); end
    step();
    start_cyc = cyc;
    start1 = 1'b0; start2 = 1'b0;
    for (int it = 0; it < 600; it++) begin
      v   = (sel == 0) ? ax1.tvalid : ax2.tvalid;
      l   = (sel == 0) ? ax1.tlast  : ax2.tlast;
      dat = (sel == 0) ? ax1.tdata  : ax2.tdata;
      b   = (sel == 0) ? busy1 : busy2;
      d   = (sel == 0) ? done1 : done2;
      e   = (sel == 0) ? en1   : en2;
      bi  = (sel == 0) ? bidx1 : bidx2;
      if (prev_stall && (!v || dat !== prev_dat || l !== prev_l)) hold_err++;
      if (e) begin issues++; got_idx.push_back(int'(bi)); end
      if (issues - got_data.size() > max_ahead) max_ahead = issues - got_data.size();
      if (v && first_valid < 0) first_valid = cyc;
      if (d) begin done_cyc = cyc; timed_out = 1'b0; break; end
      if (!b) busy_gap++;
      case (mode)
        0:       r = 1'b1;
        1:       r = ((it % 4) == 0) || ((it % 4) == 3);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      if (sel == 0) ax1.tready = r; else ax2.tready = r;
      if (v && r) begin
        got_data.push_back(dat); got_last.push_back(l); got_cyc.push_back(cyc + 1);
      end
      prev_stall = v && !r; prev_dat = dat; prev_l = l;
      if (it == restart_at) begin
        if (sel == 0) begin start1 = 1'b1; idx1 = 9'(rs_idx); sz1 = 9'(rs_sz); end
        else          begin start2 = 1'b1; idx2 = 9'(rs_idx); sz2 = 9'(rs_sz); end
      end else begin
        start1 = 1'b0; start2 = 1'b0;
      end
      step();
    end
    start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done1); end
    checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL reset_bram_en: got %0b want 0", en1); end
    checks++; if (bidx1 !== 9'd0) begin errors++; $display("FAIL reset_bram_index: got %0d want 0", bidx1); end
    checks++; if (ax1.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b want 0", ax1.tvalid); end
    checks++; if (ax1.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %0b want 0", ax1.tlast); end
    checks++; if (ax1.tdata !== 32'd0) begin errors++; $display("FAIL reset_tdata: got %0h want 0", ax1.tdata); end
    checks++; if (ax2.tvalid !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL reset_lat2: got tvalid=%0b busy=%0b want 0 0", ax2.tvalid, busy2); end
    rstn = 1'b1;
    repeat (2) step();
    checks++; if (busy1 !== 1'b0 || ax1.tvalid !== 1'b0 || en1 !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy=%0b tvalid=%0b en=%0b want 0 0 0", busy1, ax1.tvalid, en1); end
  endtask

  task automatic test_full_rate(input int sel, input int lat);
    checks++; if (timed_out) begin errors++; $display("FAIL full_rate%0d_timeout: got no done want done", lat); end
    run_xfer(sel, 0, 15, 0, -1, 0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL full_rate%0d_done: got timeout want done", lat); end
    checks++; if (got_data.size() != 16) begin errors++; $display("FAIL full_rate%0d_count: got %0d want 16", lat, got_data.size()); end
    checks++; if (first_valid != start_cyc + lat + 2) begin
      errors++; $display("FAIL full_rate%0d_first_valid: got %0d want %0d", lat, first_valid - start_cyc, lat + 2); end
    for (int k = 0; k < got_data.size(); k++) begin
      checks++; if (got_data[k] !== mem[k] || got_last[k] != (k == 15)) begin
        errors++; $display("FAIL full_rate%0d_beat%0d: got %0h/%0b want %0h/%0b", lat, k, got_data[k], got_last[k], mem[k], k == 15); end
      checks++; if (got_cyc[k] != start_cyc + lat + 3 + k) begin
        errors++; $display("FAIL full_rate%0d_timing%0d: got %0d want %0d", lat, k, got_cyc[k] - start_cyc, lat + 3 + k); end
    end
    for (int k = 0; k < got_idx.size(); k++) begin
      checks++; if (got_idx[k] != k) begin errors++; $display("FAIL full_rate%0d_index%0d: got %0d want %0d", lat, k, got_idx[k], k); end
    end
    checks++; if (got_data.size() > 0 && done_cyc != got_cyc[got_data.size()-1]) begin
      errors++; $display("FAIL full_rate%0d_done_cycle: got %0d want %0d", lat, done_cyc, got_cyc[got_data.size()-1]); end
    checks++; if (busy_gap != 0) begin errors++; $display("FAIL full_rate%0d_busy: got %0d low cycles want 0", lat, busy_gap); end
    step();
    checks++; if (((sel == 0) ? done1 : done2) !== 1'b0) begin errors++; $display("FAIL full_rate%0d_done_pulse: got 1 want 0", lat); end
  endtask

  task automatic test_backpressure();
    run_xfer(0, 0, 15, 1, -1, 0, 0);
    checks++; if (timed_out || got_data.size() != 16) begin
      errors++; $display("FAIL bp_count: got %0d beats timeout=%0b want 16", got_data.size(), timed_out); end
    for (int k = 0; k < got_data.size(); k++) begin
      checks++; if (got_data[k] !== mem[k] || got_last[k] != (k == 15)) begin
        errors++; $display("FAIL bp_beat%0d: got %0h/%0b want %0h/%0b", k, got_data[k], got_last[k], mem[k], k == 15); end
    end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_err); end
    checks++; if (max_ahead > 4) begin errors++; $display("FAIL bp_credit: got %0d ahead want <=4", max_ahead); end
    checks++; if (got_idx.size() != 16) begin errors++; $display("FAIL bp_issues: got %0d want 16", got_idx.size()); end
    step();
  endtask

  task automatic test_wrap();
    int exp_idx [4] = '{510, 511, 0, 1};
    run_xfer(0, 510, 1, 0, -1, 0, 0);
    checks++; if (got_data.size() != exp_n(510, 1) || got_idx.size() != 4) begin
      errors++; $display("FAIL wrap_count: got %0d beats %0d issues want 4 4", got_data.size(), got_idx.size()); end
    for (int k = 0; k < 4 && k < got_data.size() && k < got_idx.size(); k++) begin
      checks++; if (got_idx[k] != exp_idx[k] || got_data[k] !== mem[exp_idx[k]] || got_last[k] != (k == 3)) begin
        errors++; $display("FAIL wrap_beat%0d: got idx=%0d %0h/%0b want idx=%0d %0h/%0b",
                           k, got_idx[k], got_data[k], got_last[k], exp_idx[k], mem[exp_idx[k]], k == 3); end
    end
    step();
  endtask

  task automatic test_single_and_restart();
    int stray;
    run_xfer(0, 7, 7, 0, 1, 20, 30);
    checks++; if (timed_out || got_data.size() != 1 || got_idx.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d beats %0d issues want 1 1", got_data.size(), got_idx.size()); end
    if (got_data.size() > 0) begin
      checks++; if (got_data[0] !== mem[7] || got_last[0] !== 1'b1) begin
        errors++; $display("FAIL single_beat: got %0h/%0b want %0h/1", got_data[0], got_last[0], mem[7]); end
      checks++; if (done_cyc != got_cyc[0]) begin
        errors++; $display("FAIL single_done: got %0d want %0d", done_cyc, got_cyc[0]); end
    end
    // start asserted during the done cycle must be ignored
    start1 = 1'b1; idx1 = 9'd40; sz1 = 9'd50;
    step();
    start1 = 1'b0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (en1 || ax1.tvalid || busy1 || done1) stray++;
      step();
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL done_start_ignored: got %0d active cycles want 0", stray); end
  endtask

  task automatic test_random();
    int idx, sz, n, a;
    for (int t = 0; t < 6; t++) begin
      idx = int'($urandom_range(0, 511));
      sz  = (idx + int'($urandom_range(0, 40))) % 512;
      n   = exp_n(idx, sz);
      run_xfer(0, idx, sz, 2, -1, 0, 0);
      checks++; if (timed_out || got_data.size() != n) begin
        errors++; $display("FAIL rand%0d_count: got %0d want %0d", t, got_data.size(), n); end
      for (int k = 0; k < got_data.size() && k < n; k++) begin
        a = (idx + k) % 512;
        checks++; if (got_data[k] !== mem[a] || got_last[k] != (k == n - 1)) begin
          errors++; $display("FAIL rand%0d_beat%0d: got %0h/%0b want %0h/%0b", t, k, got_data[k], got_last[k], mem[a], k == n - 1); end
      end
      checks++; if (hold_err != 0 || max_ahead > 4) begin
        errors++; $display("FAIL rand%0d_flow: got hold_err=%0d ahead=%0d want 0 <=4", t, hold_err, max_ahead); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int issues;
    ax1.tready = 1'b0;
    start1 = 1'b1; idx1 = 9'd0; sz1 = 9'd15;
    step();
    start1 = 1'b0;
    issues = 0;
    for (int i = 0; i < 12; i++) begin
      if (en1) issues++;
      step();
    end
    checks++; if (issues != 4) begin errors++; $display("FAIL stall_issues: got %0d want 4", issues); end
    checks++; if (ax1.tvalid !== 1'b1 || busy1 !== 1'b1) begin
      errors++; $display("FAIL stall_state: got tvalid=%0b busy=%0b want 1 1", ax1.tvalid, busy1); end
    rstn = 1'b0;
    #1;
    checks++; if (ax1.tvalid !== 1'b0 || busy1 !== 1'b0 || en1 !== 1'b0 || done1 !== 1'b0) begin
      errors++; $display("FAIL async_reset: got tvalid=%0b busy=%0b en=%0b done=%0b want 0 0 0 0",
                         ax1.tvalid, busy1, en1, done1); end
    step(); step();
    rstn = 1'b1;
    step();
    run_xfer(0, 4, 5, 0, -1, 0, 0);
    checks++; if (timed_out || got_data.size() != 2) begin
      errors++; $display("FAIL post_reset_count: got %0d want 2", got_data.size()); end
    for (int k = 0; k < got_data.size() && k < 2; k++) begin
      checks++; if (got_data[k] !== mem[4 + k] || got_last[k] != (k == 1)) begin
        errors++; $display("FAIL post_reset_beat%0d: got %0h/%0b want %0h/%0b", k, got_data[k], got_last[k], mem[4 + k], k == 1); end
    end
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    start1 = 1'b0; start2 = 1'b0;
    idx1 = '0; sz1 = '0; idx2 = '0; sz2 = '0;
    ax1.tready = 1'b1; ax2.tready = 1'b1;
    timed_out = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    repeat (3) step();
    test_reset();
    test_full_rate(0, 1);
    test_backpressure();
    test_wrap();
    test_single_and_restart();
    test_random();
    test_reset_mid();
    test_full_rate(1, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
